// File: rtl/ftsd_pkg.sv
// Shared types and constants for the 4-digit 14-segment scan controller.
// Segment patterns are stored active-high; the decoder inverts them for the panel.
package ftsd_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } ftsd_state_e;

    localparam logic [14:0] SEG_OFF = 15'h7FFF;
    localparam logic [3:0]  CTL_OFF = 4'hF;

    // Bit 13..0 = a, b, c, d, e, f, g1, g2, h, i, j, k, l, m; entry 0 is rightmost below.
    localparam logic [15:0][13:0] SEG_TABLE = {
        14'h2380, 14'h2780, 14'h3C12, 14'h2700,
        14'h3C52, 14'h3BC0, 14'h3DC0, 14'h3FC0,
        14'h3800, 14'h2FC0, 14'h2DC0, 14'h19C0,
        14'h3C40, 14'h36C0, 14'h1800, 14'h3F0C
    };

    function automatic logic lz_blank(input logic [15:0] data,
                                      input logic [1:0]  idx,
                                      input logic        lz_en);
        logic zero_above;
        case (idx)
            2'd3:    zero_above = (data[15:12] == 4'h0);
            2'd2:    zero_above = (data[15:8] == 8'h00);
            2'd1:    zero_above = (data[15:4] == 12'h000);
            default: zero_above = 1'b0;
        endcase
        return lz_en && zero_above;
    endfunction

endpackage

// File: rtl/ftsd_decoder.sv
// Hex code plus decimal point to active-low 14-segment pattern; purely combinational.
// blank forces every segment and the decimal point off.
module ftsd_decoder
    import ftsd_pkg::*;
(
    input  logic [3:0]  code,
    input  logic        dp,
    input  logic        blank,
    output logic [14:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = {~SEG_TABLE[code], ~dp};
        end
    end

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// Scans four 14-segment digits with blanking gaps; outputs registered, changing with the state.
// upd_ready drops once an update is staged and rises after it commits at the next 3->0 wrap.
module ftsd_scan_ctrl
    import ftsd_pkg::*;
#(
    parameter int BLANK_CYC = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        scan_tick,
    input  logic        lz_en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_dp,
    output logic        upd_ready,
    output logic [3:0]  ftsd_ctl,
    output logic [14:0] ftsd_seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ftsd_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      act_data, act_data_nxt, stg_data;
    logic [3:0]       act_dp, act_dp_nxt, stg_dp;
    logic             pending;
    logic             commit;
    logic             xfer;
    logic [3:0]       ctl_nxt;
    logic [14:0]      seg_nxt;
    logic             dec_blank;

    assign upd_ready = !pending;
    assign xfer      = upd_valid && !pending;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        commit    = 1'b0;
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
        end else if (state == BLANK) begin
            if (cnt == CNT_LAST) begin
                state_nxt = DRIVE;
                idx_nxt   = idx + 2'd1;
                cnt_nxt   = '0;
                // Only the 3->0 wrap is a frame boundary, so a frame is never torn.
                commit    = pending && (idx == 2'd3);
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end else if (scan_tick) begin
            state_nxt = BLANK;
        end
    end

    assign act_data_nxt = commit ? stg_data : act_data;
    assign act_dp_nxt   = commit ? stg_dp   : act_dp;

    // Decode from next-state values so the registered outputs move with the state.
    assign dec_blank = (state_nxt != DRIVE) || lz_blank(act_data_nxt, idx_nxt, lz_en);
    assign ctl_nxt   = (state_nxt == DRIVE) ? ~(4'b0001 << idx_nxt) : CTL_OFF;

    ftsd_decoder u_dec (
        .code  (act_data_nxt[{idx_nxt, 2'b00} +: 4]),
        .dp    (act_dp_nxt[idx_nxt]),
        .blank (dec_blank),
        .seg   (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= 2'd3;
            act_data <= '0;
            act_dp   <= '0;
            stg_data <= '0;
            stg_dp   <= '0;
            pending  <= 1'b0;
            ftsd_ctl <= CTL_OFF;
            ftsd_seg <= SEG_OFF;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            act_data <= act_data_nxt;
            act_dp   <= act_dp_nxt;
            if (xfer) begin
                stg_data <= upd_data;
                stg_dp   <= upd_dp;
            end
            if (commit) begin
                pending <= 1'b0;
            end else if (xfer) begin
                pending <= 1'b1;
            end
            ftsd_ctl <= ctl_nxt;
            ftsd_seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// Scoreboard bench for ftsd_scan_ctrl: stimulus queues expected digits, a monitor
// pops one per displayed digit and checks pattern, blank gap and lit duration.
module tb_ftsd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        scan_tick;
    logic        lz_en;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic        upd_ready;
    logic [3:0]  ftsd_ctl;
    logic [14:0] ftsd_seg;

    always #5 clk = ~clk;

    ftsd_scan_ctrl #(.BLANK_CYC(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scan_tick (scan_tick),
        .lz_en     (lz_en),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .upd_dp    (upd_dp),
        .upd_ready (upd_ready),
        .ftsd_ctl  (ftsd_ctl),
        .ftsd_seg  (ftsd_seg)
    );

    // Hand-drawn glyphs, bit 13..0 = a,b,c,d,e,f,g1,g2,h,i,j,k,l,m.
    localparam logic [13:0] P0 = 14'h3F0C;
    localparam logic [13:0] P1 = 14'h1800;
    localparam logic [13:0] P2 = 14'h36C0;
    localparam logic [13:0] P3 = 14'h3C40;
    localparam logic [13:0] P4 = 14'h19C0;
    localparam logic [13:0] P5 = 14'h2DC0;
    localparam logic [13:0] P9 = 14'h3DC0;
    localparam logic [13:0] PA = 14'h3BC0;
    localparam logic [13:0] PB = 14'h3C52;
    localparam logic [13:0] PC = 14'h2700;
    localparam logic [13:0] PD = 14'h3C12;
    localparam logic [14:0] OFF = 15'h7FFF;

    typedef struct {
        logic [3:0]  ctl;
        logic [14:0] seg;
        int          gap;
        int          lit;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         have_cur;
    logic [3:0] prev_ctl;
    int         off_cnt;
    int         lit_cnt;
    int         checks;
    int         errors;

    function automatic logic [14:0] sg(input logic [13:0] p, input logic dp_lit);
        return {~p, ~dp_lit};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [14:0] s, input int g, input int l);
        exp_t e;
        e.ctl = c;
        e.seg = s;
        e.gap = g;
        e.lit = l;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, input int first, input int period);
        for (int i = 0; i < n; i++) begin
            cyc((i == 0) ? first - 1 : period - 1);
            scan_tick = 1'b1;
            cyc(1);
            scan_tick = 1'b0;
        end
    endtask

    task automatic send_wait(output int n);
        logic hs;
        n = 0;
        do begin
            hs = upd_ready;
            cyc(1);
            n++;
        end while (!hs && n < 64);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ctl = 4'hF;
                off_cnt  = 0;
                lit_cnt  = 0;
                have_cur = 1'b0;
            end else begin
                if (prev_ctl != 4'hF && ftsd_ctl != prev_ctl) begin
                    if (have_cur && cur.lit != 0) check("lit_cycles", lit_cnt, cur.lit);
                    have_cur = 1'b0;
                end
                if (ftsd_ctl == 4'hF) begin
                    check("off_seg", 32'(ftsd_seg), 32'(OFF));
                    off_cnt++;
                end else if (ftsd_ctl != prev_ctl) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_digit: ctl 0x%0h seg 0x%0h, none expected at %0t",
                                 ftsd_ctl, ftsd_seg, $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("digit_ctl", 32'(ftsd_ctl), 32'(cur.ctl));
                        check("digit_seg", 32'(ftsd_seg), 32'(cur.seg));
                        if (cur.gap != 0) check("blank_cycles", off_cnt, cur.gap);
                    end
                    off_cnt = 0;
                    lit_cnt = 1;
                end else begin
                    lit_cnt++;
                    if (have_cur) check("hold_seg", 32'(ftsd_seg), 32'(cur.seg));
                end
                prev_ctl = ftsd_ctl;
            end
        end
    endtask

    task automatic stimulus();
        int n;
        rst_n = 1'b0; en = 1'b1; scan_tick = 1'b0; lz_en = 1'b0;
        upd_valid = 1'b0; upd_data = '0; upd_dp = '0;

        // Reset asserted while a digit is being driven.
        cyc(3);
        rst_n = 1'b1;
        push(4'hE, sg(P0, 1'b0), 4, 0);
        cyc(6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", 32'(ftsd_ctl), 32'hF);
        check("rst_async_seg", 32'(ftsd_seg), 32'(OFF));
        check("rst_async_ready", 32'(upd_ready), 1);
        cyc(1);
        rst_n = 1'b1;

        // Basic scan of 1234.
        check("rst_ready", 32'(upd_ready), 1);
        push(4'hE, sg(P4, 1'b0), 4, 12);
        push(4'hD, sg(P3, 1'b0), 4, 12);
        push(4'hB, sg(P2, 1'b0), 4, 12);
        push(4'h7, sg(P1, 1'b0), 4, 12);
        upd_valid = 1'b1; upd_data = 16'h1234; upd_dp = 4'h0;
        cyc(1);
        upd_valid = 1'b0;
        check("load_busy", 32'(upd_ready), 0);
        cyc(3);
        check("load_commit", 32'(upd_ready), 1);
        run_ticks(4, 12, 16);

        // ABCD arrives mid-frame; old frame completes first.
        push(4'hE, sg(P4, 1'b0), 4, 12);
        push(4'hD, sg(P3, 1'b0), 4, 12);
        push(4'hB, sg(P2, 1'b0), 4, 12);
        push(4'h7, sg(P1, 1'b0), 4, 12);
        push(4'hE, sg(PD, 1'b1), 4, 12);
        push(4'hD, sg(PC, 1'b0), 4, 12);
        push(4'hB, sg(PB, 1'b0), 4, 12);
        push(4'h7, sg(PA, 1'b0), 4, 12);
        fork
            run_ticks(8, 16, 16);
            begin
                cyc(24);
                upd_valid = 1'b1; upd_data = 16'hABCD; upd_dp = 4'b0001;
                cyc(1);
                upd_valid = 1'b0;
                check("tear_busy", 32'(upd_ready), 0);
                cyc(42);
                check("tear_hold", 32'(upd_ready), 0);
                cyc(1);
                check("tear_commit", 32'(upd_ready), 1);
            end
        join

        // Back-to-back loads with valid held.
        push(4'hE, sg(P1, 1'b0), 4, 12);
        push(4'hD, sg(P0, 1'b0), 4, 12);
        push(4'hB, sg(P0, 1'b0), 4, 12);
        push(4'h7, sg(P0, 1'b0), 4, 12);
        push(4'hE, sg(P2, 1'b0), 4, 12);
        push(4'hD, sg(P0, 1'b0), 4, 12);
        push(4'hB, sg(P0, 1'b0), 4, 12);
        push(4'h7, sg(P0, 1'b0), 4, 12);
        fork
            run_ticks(8, 16, 16);
            begin
                upd_valid = 1'b1; upd_data = 16'h0001; upd_dp = 4'h0;
                send_wait(n);
                check("b2b_first_wait", n, 1);
                upd_data = 16'h0002;
                send_wait(n);
                check("b2b_second_wait", n, 4);
                upd_valid = 1'b0;
                check("b2b_busy", 32'(upd_ready), 0);
                cyc(62);
                check("b2b_hold", 32'(upd_ready), 0);
                cyc(1);
                check("b2b_commit", 32'(upd_ready), 1);
            end
        join

        // Leading-zero suppression.
        lz_en = 1'b1;
        push(4'hE, sg(P0, 1'b0), 4, 12);
        push(4'hD, sg(P5, 1'b0), 4, 12);
        push(4'hB, OFF, 4, 12);
        push(4'h7, OFF, 4, 12);
        push(4'hE, sg(P0, 1'b1), 4, 12);
        push(4'hD, OFF, 4, 12);
        push(4'hB, OFF, 4, 12);
        push(4'h7, OFF, 4, 12);
        fork
            run_ticks(8, 16, 16);
            begin
                upd_valid = 1'b1; upd_data = 16'h0050; upd_dp = 4'h0;
                cyc(1);
                upd_valid = 1'b0;
                cyc(9);
                upd_valid = 1'b1; upd_data = 16'h0000; upd_dp = 4'hF;
                cyc(1);
                upd_valid = 1'b0;
                check("lz_busy", 32'(upd_ready), 0);
            end
        join

        // Enable low for 20 cycles, then a tick on every cycle.
        lz_en = 1'b0;
        push(4'hE, sg(P0, 1'b1), 4, 4);
        push(4'hD, sg(P0, 1'b1), 23, 1);
        push(4'hB, sg(P0, 1'b1), 4, 1);
        push(4'h7, sg(P0, 1'b1), 4, 1);
        push(4'hE, sg(P9, 1'b0), 4, 1);
        push(4'hD, sg(P0, 1'b0), 4, 1);
        push(4'hB, sg(P0, 1'b0), 4, 1);
        push(4'h7, sg(P0, 1'b0), 4, 0);
        cyc(7);
        en = 1'b0;
        cyc(5);
        upd_valid = 1'b1; upd_data = 16'h0009; upd_dp = 4'h0;
        cyc(1);
        upd_valid = 1'b0;
        check("en_busy", 32'(upd_ready), 0);
        cyc(14);
        check("en_no_commit", 32'(upd_ready), 0);
        check("en_dark_ctl", 32'(ftsd_ctl), 32'hF);
        en = 1'b1;
        cyc(4);
        scan_tick = 1'b1;
        cyc(14);
        check("burst_pre_wrap", 32'(upd_ready), 0);
        cyc(1);
        check("burst_wrap_commit", 32'(upd_ready), 1);
        cyc(11);
        scan_tick = 1'b0;
        cyc(8);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_ctl = 4'hF;
        off_cnt  = 0;
        lit_cnt  = 0;
        have_cur = 1'b0;
        fork
            monitor();
            stimulus();
            begin
                #200000;
                checks++;
                errors++;
                $display("FAIL timeout: stimulus still running at %0t, limit 200000", $time);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
